vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator for the display path, clocked by the pixel clock. It produces horizontal and vertical counters, sync pulses of configurable polarity, a `video_on` active-area flag, and line/frame start strobes. It also provides copies of the sync and `video_on` outputs delayed to match a pixel-generation pipeline of configurable depth. It sits between the clock/reset block and the game renderer/VGA output pins.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level (0 = active-low)
- `PIPE_DLY`, 2, renderer latency in enabled cycles, range 0..8
- `CW`, derived, `$clog2(max(H_TOTAL, V_TOTAL))`; H_TOTAL/V_TOTAL are the sums of the four terms
- `pxl_clk  in  1  pixel clock`
- `reset_n  in  1  asynchronous, active-low reset`
- `pix_en  in  1  pixel-rate clock enable; tie 1 if pxl_clk is already the pixel rate`
- `hcount  out  CW  horizontal position, 0..H_TOTAL-1`
- `vcount  out  CW  vertical position, 0..V_TOTAL-1`
- `video_on  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE`
- `hsync, vsync  out  1  sync pulses, aligned to counters`
- `line_start  out  1  high while hcount==0`
- `frame_start  out  1  high while hcount==0 and vcount==0`
- `hsync_d, vsync_d, video_on_d  out  1  same signals delayed PIPE_DLY enabled cycles`

Reset: `reset_n`, asynchronous, active-low; clock: `pxl_clk`.

## Operation
- All outputs are registered. Decode from next-state counter values so that every flag is coherent with the `hcount`/`vcount` presented in the same cycle.
- **Reset values:**
  - `hcount` = H_TOTAL-1, `vcount` = V_TOTAL-1.
  - `video_on`, `line_start`, `frame_start` = 0.
  - `hsync` = !HS_POL, `vsync` = !VS_POL.
  - All delay-line stages hold these same values.
- **Horizontal counting:** on each `pix_en` cycle, `hcount` increments. At H_TOTAL-1 it wraps to 0.
- **Vertical counting:** `vcount` increments only on the cycle where `hcount` wraps. At V_TOTAL-1 it wraps to 0, coincident with the `hcount` wrap.
- **Sync decode:**
  - hsync is active (=HS_POL) for `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync is active (=VS_POL) for `vcount` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], across whole lines.
- **`pix_en` low:** counters, all outputs and the delay line hold. Strobes stay at their current value; the sink qualifies them with `pix_en`.
- **Delay line (`PIPE_DLY`):**
  - For `PIPE_DLY`=0, the `_d` outputs equal the undelayed outputs.
  - Otherwise it is a shift register advanced only on `pix_en`.
- **Reset mid-frame:** immediate return to reset values, including the delay line.
- **Elaboration checks:** every timing parameter must be ≥1, and `PIPE_DLY` ≤8. A violation is a fatal error.

## Timing
- First `pix_en` edge after reset release gives `hcount`=0, `vcount`=0, `video_on`=1, `line_start`=1, `frame_start`=1.
- Counter-to-flag latency is 0 cycles: flags match the counts in the same cycle.
- Line period is H_TOTAL enabled cycles (800 default).
- Frame period is H_TOTAL×V_TOTAL enabled cycles (420000 default).
- `_d` outputs equal the undelayed value from exactly `PIPE_DLY` enabled cycles earlier.

## Structure
- Package `vga_timing_pkg` holds:
  - default 640×480@60 timing constants;
  - an 800×600 constant set;
  - a `max` function used for `CW`.
- Sub-module `vga_sync_delay` (parameters WIDTH, DEPTH) is an enabled shift register with DEPTH=0 passthrough. Instantiate it once, with WIDTH=3, for `hsync`/`vsync`/`video_on`.

## Test plan
- **Default parameters, `pix_en`=1, 2 frames:**
  - 800 cycles per line and 420000 per frame;
  - hsync low for exactly 96 cycles starting at `hcount`=656;
  - vsync low for lines 490–491;
  - `video_on` high 640×480 cycles per frame.
- **Reset release:** first edge → (0,0) with `frame_start`=1. `frame_start` recurs every 420000 cycles and `line_start` every 800 cycles.
- **`pix_en` pulsed 1-in-4:** all periods scale ×4. Outputs are stable between enabled cycles.
- **Small config and polarity:**
  - H=4/1/2/1, V=3/1/1/1, HS_POL=1, VS_POL=1, PIPE_DLY=0.
  - hsync is high at `hcount` 5–6 and vsync high at `vcount` 4.
  - `_d` outputs equal the undelayed outputs.
- **PIPE_DLY=3:** `video_on_d` rises exactly 3 enabled cycles after `video_on`, with `pix_en` gaps inserted.
- **Reset asserted at (300,200):** outputs go to reset values asynchronously, and the delay line is cleared. After release, the generator restarts at (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Raster timing constant sets and helpers shared by the
//               display timing path.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

   // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam bit VGA_HS_POL   = 1'b0;
   localparam bit VGA_VS_POL   = 1'b0;

   // 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs
   localparam int SVGA_H_ACTIVE = 800;
   localparam int SVGA_H_FP     = 40;
   localparam int SVGA_H_SYNC   = 128;
   localparam int SVGA_H_BP     = 88;
   localparam int SVGA_V_ACTIVE = 600;
   localparam int SVGA_V_FP     = 1;
   localparam int SVGA_V_SYNC   = 4;
   localparam int SVGA_V_BP     = 23;
   localparam bit SVGA_HS_POL   = 1'b1;
   localparam bit SVGA_VS_POL   = 1'b1;

   // Larger of two integers; used to size the shared counter width
   function automatic int max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_delay
// Description : Enable-qualified shift register that re-times sync/blank
//               flags to match the renderer pipeline. DEPTH=0 is a wire.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_delay #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             pxl_clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ctrl;
         // No pipeline to match: forward the flags unchanged
         assign unused_ctrl = &{1'b0, pxl_clk, reset_n, en};
         assign dout        = din;
      end else begin : g_shift
         logic [WIDTH-1:0] stage [DEPTH];

         // Shift one stage per enabled pixel; reset loads the idle flag values
         always_ff @(posedge pxl_clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= RST_VAL;
               end
            end else if (en) begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator: h/v counters, sync
//               pulses, active-video flag, line/frame strobes and copies of
//               the syncs/blank delayed to match the pixel pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit HS_POL   = VGA_HS_POL,
   parameter bit VS_POL   = VGA_VS_POL,
   parameter int PIPE_DLY = 2,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int CW      = $clog2(max(H_TOTAL, V_TOTAL))
) (
   input  logic          pxl_clk,
   input  logic          reset_n,
   input  logic          pix_en,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          video_on,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start,
   output logic          hsync_d,
   output logic          vsync_d,
   output logic          video_on_d
);

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Reject degenerate timings and over-deep pipelines at elaboration
   generate
      if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
          V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
         $fatal(1, "vga_timing_gen: every timing parameter must be >= 1");
      end
      if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_bad_dly
         $fatal(1, "vga_timing_gen: PIPE_DLY must be in 0..8");
      end
   endgenerate

   logic          h_wrap;
   logic [CW-1:0] h_next;
   logic [CW-1:0] v_next;
   logic [2:0]    dly_out;

   // Next-state counter values; flags are decoded from these so they line up
   // with the counts presented in the same cycle
   always_comb begin
      h_wrap = (hcount == H_LAST);
      h_next = h_wrap ? '0 : hcount + 1'b1;
      v_next = vcount;
      if (h_wrap) begin
         v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end
   end

   // Counter and flag registers; reset parks at the last pixel of the frame so
   // the first enabled edge lands on (0,0)
   always_ff @(posedge pxl_clk or negedge reset_n) begin
      if (!reset_n) begin
         hcount      <= H_LAST;
         vcount      <= V_LAST;
         video_on    <= 1'b0;
         hsync       <= !HS_POL;
         vsync       <= !VS_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         hcount      <= h_next;
         vcount      <= v_next;
         video_on    <= (h_next < H_ACT) && (v_next < V_ACT);
         hsync       <= ((h_next >= HS_START) && (h_next <= HS_END)) ? HS_POL : !HS_POL;
         vsync       <= ((v_next >= VS_START) && (v_next <= VS_END)) ? VS_POL : !VS_POL;
         line_start  <= (h_next == '0);
         frame_start <= (h_next == '0) && (v_next == '0);
      end
   end

   vga_sync_delay #(
      .WIDTH   (3),
      .DEPTH   (PIPE_DLY),
      .RST_VAL ({!HS_POL, !VS_POL, 1'b0})
   ) u_sync_delay (
      .pxl_clk (pxl_clk),
      .reset_n (reset_n),
      .en      (pix_en),
      .din     ({hsync, vsync, video_on}),
      .dout    (dly_out)
   );

   assign hsync_d    = dly_out[2];
   assign vsync_d    = dly_out[1];
   assign video_on_d = dly_out[0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic en_def, en_sm, en_d3;

   int n_cmp = 0;
   int n_bad = 0;

   // Default 640x480 instance, PIPE_DLY=2
   logic [9:0] def_h, def_v;
   logic def_von, def_hs, def_vs, def_ls, def_fs, def_hsd, def_vsd, def_vond;
   vga_timing_gen u_def (
      .pxl_clk(clk), .reset_n(reset_n), .pix_en(en_def),
      .hcount(def_h), .vcount(def_v), .video_on(def_von),
      .hsync(def_hs), .vsync(def_vs), .line_start(def_ls), .frame_start(def_fs),
      .hsync_d(def_hsd), .vsync_d(def_vsd), .video_on_d(def_vond));

   // Tiny raster (8x6), positive syncs, no delay
   logic [2:0] sm_h, sm_v;
   logic sm_von, sm_hs, sm_vs, sm_ls, sm_fs, sm_hsd, sm_vsd, sm_vond;
   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
   ) u_small (
      .pxl_clk(clk), .reset_n(reset_n), .pix_en(en_sm),
      .hcount(sm_h), .vcount(sm_v), .video_on(sm_von),
      .hsync(sm_hs), .vsync(sm_vs), .line_start(sm_ls), .frame_start(sm_fs),
      .hsync_d(sm_hsd), .vsync_d(sm_vsd), .video_on_d(sm_vond));

   // Tiny raster, negative syncs, 3-deep delay line
   logic [2:0] d3_h, d3_v;
   logic d3_von, d3_hs, d3_vs, d3_ls, d3_fs, d3_hsd, d3_vsd, d3_vond;
   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3)
   ) u_d3 (
      .pxl_clk(clk), .reset_n(reset_n), .pix_en(en_d3),
      .hcount(d3_h), .vcount(d3_v), .video_on(d3_von),
      .hsync(d3_hs), .vsync(d3_vs), .line_start(d3_ls), .frame_start(d3_fs),
      .hsync_d(d3_hsd), .vsync_d(d3_vsd), .video_on_d(d3_vond));

   typedef struct {
      int adv;
      int h;
      int v;
      bit von, hs, vs, ls, fs, hsd, vond;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference raster position advance for an 8x6 frame
   function automatic void adv8x6(inout int h, inout int v);
      h = (h == 7) ? 0 : h + 1;
      if (h == 0) v = (v == 5) ? 0 : v + 1;
   endfunction

   int  eh, ev, dh, dv, k;
   int  cnt_fs, cnt_ls, cnt_von, cnt_hs, cnt_vs;
   int  fs_rise0, fs_rise1, ls_rise0, ls_rise1;
   int  rise_on, rise_d;
   bit  prev_fs, prev_ls;
   bit  e_von, e_hs, e_vs, e_ls, e_fs;
   bit  h_von [0:63];
   bit  h_hs  [0:63];
   bit  h_vs  [0:63];
   logic [13:0] exp_sm;

   initial begin
      // adv, h, v, von, hs, vs, ls, fs, hsd, vond
      tbl[0]  = '{1,   0,   0, 1, 1, 1, 1, 1, 1, 0};
      tbl[1]  = '{1,   1,   0, 1, 1, 1, 0, 0, 1, 0};
      tbl[2]  = '{1,   2,   0, 1, 1, 1, 0, 0, 1, 1};
      tbl[3]  = '{637, 639, 0, 1, 1, 1, 0, 0, 1, 1};
      tbl[4]  = '{1,   640, 0, 0, 1, 1, 0, 0, 1, 1};
      tbl[5]  = '{2,   642, 0, 0, 1, 1, 0, 0, 1, 0};
      tbl[6]  = '{14,  656, 0, 0, 0, 1, 0, 0, 1, 0};
      tbl[7]  = '{2,   658, 0, 0, 0, 1, 0, 0, 0, 0};
      tbl[8]  = '{93,  751, 0, 0, 0, 1, 0, 0, 0, 0};
      tbl[9]  = '{1,   752, 0, 0, 1, 1, 0, 0, 0, 0};
      tbl[10] = '{2,   754, 0, 0, 1, 1, 0, 0, 1, 0};
      tbl[11] = '{45,  799, 0, 0, 1, 1, 0, 0, 1, 0};
      tbl[12] = '{1,   0,   1, 1, 1, 1, 1, 0, 1, 0};
      tbl[13] = '{800, 0,   2, 1, 1, 1, 1, 0, 1, 0};
      tbl[14] = '{300, 300, 2, 1, 1, 1, 0, 0, 1, 1};

      reset_n = 1'b0;
      en_def  = 1'b0;
      en_sm   = 1'b0;
      en_d3   = 1'b0;
      repeat (3) step();

      // Reset state of all three instances
      chk("def rst hcount", 32'(def_h), 32'd799);
      chk("def rst vcount", 32'(def_v), 32'd524);
      chk("def rst flags", 32'({def_von, def_hs, def_vs, def_ls, def_fs, def_hsd, def_vsd, def_vond}),
          32'(8'b0_1_1_0_0_1_1_0));
      chk("sm rst state", 32'({sm_h, sm_v, sm_von, sm_hs, sm_vs, sm_ls, sm_fs}), 32'({3'd7, 3'd5, 5'b0}));
      chk("d3 rst state", 32'({d3_h, d3_v, d3_von, d3_hs, d3_vs, d3_hsd, d3_vsd, d3_vond}),
          32'({3'd7, 3'd5, 6'b0_1_1_1_1_0}));

      // Default timing checkpoints with pix_en held high
      reset_n = 1'b1;
      en_def  = 1'b1;
      foreach (tbl[i]) begin
         repeat (tbl[i].adv) step();
         chk($sformatf("def[%0d] hcount", i), 32'(def_h), 32'(tbl[i].h));
         chk($sformatf("def[%0d] vcount", i), 32'(def_v), 32'(tbl[i].v));
         chk($sformatf("def[%0d] flags", i),
             32'({def_von, def_hs, def_vs, def_ls, def_fs, def_hsd, def_vond}),
             32'({tbl[i].von, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs, tbl[i].hsd, tbl[i].vond}));
      end

      // Asynchronous reset in the middle of line 2, no clock edge in between
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst hcount", 32'(def_h), 32'd799);
      chk("midrst vcount", 32'(def_v), 32'd524);
      chk("midrst flags", 32'({def_von, def_hs, def_vs, def_ls, def_fs, def_hsd, def_vsd, def_vond}),
          32'(8'b0_1_1_0_0_1_1_0));
      step();
      reset_n = 1'b1;
      step();
      chk("restart pos", 32'({def_h, def_v}), 32'd0);
      chk("restart flags", 32'({def_von, def_ls, def_fs, def_hsd, def_vond}), 32'(5'b1_1_1_1_0));
      step();
      chk("restart dly cleared", 32'({def_hsd, def_vsd, def_vond}), 32'(3'b110));
      en_def = 1'b0;

      // Small raster, pix_en always high, two full frames
      eh = 7; ev = 5;
      cnt_fs = 0; cnt_ls = 0; cnt_von = 0; cnt_hs = 0; cnt_vs = 0;
      en_sm = 1'b1;
      for (int c = 0; c < 96; c++) begin
         step();
         adv8x6(eh, ev);
         e_von = (eh < 4) && (ev < 3);
         e_hs  = (eh == 5) || (eh == 6);
         e_vs  = (ev == 4);
         e_ls  = (eh == 0);
         e_fs  = (eh == 0) && (ev == 0);
         exp_sm = {3'(eh), 3'(ev), e_von, e_hs, e_vs, e_ls, e_fs, e_hs, e_vs, e_von};
         chk($sformatf("sm full c%0d", c),
             32'({sm_h, sm_v, sm_von, sm_hs, sm_vs, sm_ls, sm_fs, sm_hsd, sm_vsd, sm_vond}), 32'(exp_sm));
         cnt_fs  += int'(sm_fs);
         cnt_ls  += int'(sm_ls);
         cnt_von += int'(sm_von);
         cnt_hs  += int'(sm_hs);
         cnt_vs  += int'(sm_vs);
      end
      chk("sm frame_start count", 32'(cnt_fs), 32'd2);
      chk("sm line_start count", 32'(cnt_ls), 32'd12);
      chk("sm video_on count", 32'(cnt_von), 32'd24);
      chk("sm hsync count", 32'(cnt_hs), 32'd24);
      chk("sm vsync count", 32'(cnt_vs), 32'd16);

      // Small raster, pix_en 1-in-4: outputs hold between enables, periods x4
      fs_rise0 = -1; fs_rise1 = -1; ls_rise0 = -1; ls_rise1 = -1;
      prev_fs = sm_fs; prev_ls = sm_ls;
      for (int c = 0; c < 384; c++) begin
         en_sm = (c % 4 == 0);
         step();
         if (en_sm) adv8x6(eh, ev);
         e_von = (eh < 4) && (ev < 3);
         e_hs  = (eh == 5) || (eh == 6);
         e_vs  = (ev == 4);
         e_ls  = (eh == 0);
         e_fs  = (eh == 0) && (ev == 0);
         exp_sm = {3'(eh), 3'(ev), e_von, e_hs, e_vs, e_ls, e_fs, e_hs, e_vs, e_von};
         chk($sformatf("sm gated c%0d", c),
             32'({sm_h, sm_v, sm_von, sm_hs, sm_vs, sm_ls, sm_fs, sm_hsd, sm_vsd, sm_vond}), 32'(exp_sm));
         if (sm_fs && !prev_fs) begin
            if (fs_rise0 < 0) fs_rise0 = c; else if (fs_rise1 < 0) fs_rise1 = c;
         end
         if (sm_ls && !prev_ls) begin
            if (ls_rise0 < 0) ls_rise0 = c; else if (ls_rise1 < 0) ls_rise1 = c;
         end
         prev_fs = sm_fs;
         prev_ls = sm_ls;
      end
      chk("sm gated frame period", 32'(fs_rise1 - fs_rise0), 32'd192);
      chk("sm gated line period", 32'(ls_rise1 - ls_rise0), 32'd32);
      en_sm = 1'b0;

      // Delay line of 3 with gaps in pix_en
      dh = 7; dv = 5; k = 0; rise_on = -1; rise_d = -1;
      h_von[0] = 1'b0; h_hs[0] = 1'b1; h_vs[0] = 1'b1;
      for (int c = 0; c < 60; c++) begin
         en_d3 = (c % 3 != 2);
         step();
         if (en_d3) begin
            k++;
            adv8x6(dh, dv);
            h_von[k] = (dh < 4) && (dv < 3);
            h_hs[k]  = !((dh == 5) || (dh == 6));
            h_vs[k]  = !(dv == 4);
         end
         chk($sformatf("d3 c%0d", c),
             32'({d3_h, d3_v, d3_von, d3_hs, d3_vs, d3_vond, d3_hsd, d3_vsd}),
             32'({3'(dh), 3'(dv), h_von[k], h_hs[k], h_vs[k],
                  (k >= 3) ? h_von[k-3] : 1'b0,
                  (k >= 3) ? h_hs[k-3]  : 1'b1,
                  (k >= 3) ? h_vs[k-3]  : 1'b1}));
         if (d3_von && rise_on < 0) rise_on = k;
         if (d3_vond && rise_d < 0) rise_d = k;
      end
      chk("d3 video_on_d lag", 32'(rise_d - rise_on), 32'd3);
      en_d3 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
